// File: rtl/fixpoint_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : fixpoint_seq_if
// Purpose  : Request/acknowledge bus to an external combinational step evaluator.
// Revision : 1.0 - initial release
// ============================================================================
interface fixpoint_seq_if #(
   parameter int W = 9
);
   logic         eval_req;
   logic [W-1:0] eval_cur;
   logic         eval_ack;
   logic [W-1:0] eval_nxt;

   modport master (
      output eval_req,
      output eval_cur,
      input  eval_ack,
      input  eval_nxt
   );

   modport slave (
      input  eval_req,
      input  eval_cur,
      output eval_ack,
      output eval_nxt
   );
endinterface
`default_nettype wire

// File: rtl/fixpoint_seq.sv
`default_nettype none
// ============================================================================
// Module   : fixpoint_seq
// Purpose  : Iterates state through an external evaluator until it stops
//            changing (fixpoint) or MAX_ITER updates have been made (timeout).
// Revision : 1.0 - initial release
// ============================================================================
module fixpoint_seq #(
   parameter int W        = 9,
   parameter int MAX_ITER = 64,
   parameter int CNT_W    = 7
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             start,
   input  wire logic             abort,
   input  wire logic [W-1:0]     init_state,
   fixpoint_seq_if.master        eval,
   output logic                  busy,
   output logic                  done,
   output logic                  converged,
   output logic                  timeout,
   output logic [CNT_W-1:0]      iter_count,
   output logic [W-1:0]          fix_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] c_max_iter = CNT_W'(MAX_ITER);

   state_t           r_state;
   logic [W-1:0]     r_cur;
   logic [W-1:0]     r_nxt_q;
   logic             r_eval_req;
   logic             r_busy;
   logic             r_done;
   logic             r_conv;
   logic             r_to;
   logic [CNT_W-1:0] r_iter;
   logic [W-1:0]     r_fix;
   logic [CNT_W-1:0] w_iter_inc;

   assign w_iter_inc = r_iter + CNT_W'(1);

   // Output flags are registered alongside every state transition.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cur      <= '0;
         r_nxt_q    <= '0;
         r_eval_req <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_conv     <= 1'b0;
         r_to       <= 1'b0;
         r_iter     <= '0;
         r_fix      <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_cur      <= init_state;
                  r_iter     <= '0;
                  r_conv     <= 1'b0;
                  r_to       <= 1'b0;
                  r_state    <= REQ;
                  r_eval_req <= 1'b1;
                  r_busy     <= 1'b1;
               end
            end
            REQ: begin
               if (abort) begin
                  r_state    <= IDLE;
                  r_eval_req <= 1'b0;
                  r_busy     <= 1'b0;
                  r_conv     <= 1'b0;
                  r_to       <= 1'b0;
               end else if (eval.eval_ack) begin
                  r_nxt_q    <= eval.eval_nxt;
                  r_state    <= CHECK;
                  r_eval_req <= 1'b0;
               end
            end
            CHECK: begin
               if (abort) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_conv  <= 1'b0;
                  r_to    <= 1'b0;
               end else if (r_nxt_q == r_cur) begin
                  r_conv  <= 1'b1;
                  r_fix   <= r_cur;
                  r_state <= DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_cur  <= r_nxt_q;
                  r_iter <= w_iter_inc;
                  // The counter stops exactly at MAX_ITER, so it can never wrap.
                  if (w_iter_inc == c_max_iter) begin
                     r_to    <= 1'b1;
                     r_fix   <= r_nxt_q;
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state    <= REQ;
                     r_eval_req <= 1'b1;
                  end
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               if (abort) begin
                  r_conv <= 1'b0;
                  r_to   <= 1'b0;
               end
            end
            default: begin
               r_state    <= IDLE;
               r_eval_req <= 1'b0;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

   assign eval.eval_req = r_eval_req;
   assign eval.eval_cur = r_cur;
   assign busy          = r_busy;
   assign done          = r_done;
   assign converged     = r_conv;
   assign timeout       = r_to;
   assign iter_count    = r_iter;
   assign fix_state     = r_fix;

endmodule
`default_nettype wire
